// File: rtl/mdu_if.sv
// Issue/writeback bundle for the iterative multiply/divide unit.
// DivZero exists only when MDU_DIVZERO_FLAG_EN is defined.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cancel;
  logic             HI_WE;
  logic             LO_WE;
  logic [WIDTH-1:0] W_Data;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
`ifdef MDU_DIVZERO_FLAG_EN
  logic             DivZero;

  modport master (
    output Start, Op, A, B, Cancel,
    output HI_WE, LO_WE, W_Data,
    input  Busy, Done, HI, LO, DivZero
  );
  modport slave (
    input  Start, Op, A, B, Cancel,
    input  HI_WE, LO_WE, W_Data,
    output Busy, Done, HI, LO, DivZero
  );
`else
  modport master (
    output Start, Op, A, B, Cancel,
    output HI_WE, LO_WE, W_Data,
    input  Busy, Done, HI, LO
  );
  modport slave (
    input  Start, Op, A, B, Cancel,
    input  HI_WE, LO_WE, W_Data,
    output Busy, Done, HI, LO
  );
`endif
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers, one bit per clock.
// Optional MDU_DIVZERO_FLAG_EN adds a DivZero flag pulsed with Done.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic  CLK,
  input logic  RST_N,
  mdu_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_a_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mq_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mq_d;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             div_zero;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  assign a_neg = ~bus.Op[0] & bus.A[WIDTH-1];
  assign b_neg = ~bus.Op[0] & bus.B[WIDTH-1];
  assign a_mag = a_neg ? -bus.A : bus.A;
  assign b_mag = b_neg ? -bus.B : bus.B;

  // mq holds multiplier (mul) or dividend/quotient (div); opb the other operand
  assign mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
  assign div_sh   = {acc_q, mq_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb_q};

  always_comb begin
    acc_d = mul_sum[WIDTH:1];
    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
    if (is_div_q) begin
      acc_d = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      mq_d  = {mq_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end
  end

  assign prod     = {acc_q, mq_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign q_fix    = neg_res_q ? -mq_q : mq_q;
  assign r_fix    = neg_a_q ? -acc_q : acc_q;
  assign div_zero = is_div_q & (opb_q == '0);

  always_comb begin
    hi_d = prod_fix[2*WIDTH-1:WIDTH];
    lo_d = prod_fix[WIDTH-1:0];
    if (div_zero) begin
      hi_d = a_q;
      lo_d = '1;
    end else if (is_div_q) begin
      hi_d = r_fix;
      lo_d = q_fix;
    end
  end

`ifdef MDU_DIVZERO_FLAG_EN
  logic divz_q;
  assign bus.DivZero = divz_q;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      acc_q     <= '0;
      mq_q      <= '0;
      opb_q     <= '0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
      divz_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
      divz_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (bus.HI_WE) hi_q <= bus.W_Data;
          if (bus.LO_WE) lo_q <= bus.W_Data;
          if (bus.Start) begin
            state_q   <= CALC;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            acc_q     <= '0;
            is_div_q  <= bus.Op[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_a_q   <= a_neg;
            a_q       <= bus.A;
            mq_q      <= bus.Op[1] ? a_mag : b_mag;
            opb_q     <= bus.Op[1] ? b_mag : a_mag;
          end
        end
        CALC: begin
          if (bus.Cancel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            mq_q  <= mq_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!bus.Cancel) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= 1'b1;
`ifdef MDU_DIVZERO_FLAG_EN
            divz_q <= div_zero;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised self-checking bench for mult_div_unit against a 64-bit arithmetic model.
// Build with MDU_DIVZERO_FLAG_EN to also check the DivZero flag.
module tb_mult_div_unit;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  mdu_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  function automatic logic [63:0] ref_mdu(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    if (op == 2'd0) begin
      p = 64'(sa * sb);
    end else if (op == 2'd1) begin
      p = {32'd0, a} * {32'd0, b};
    end else if (b == 32'd0) begin
      p = {a, 32'hFFFF_FFFF};
    end else if (op == 2'd3) begin
      p = {a % b, a / b};
    end else begin
      q = sa / sb;
      r = sa % sb;
      p = {r[31:0], q[31:0]};
    end
    return p;
  endfunction

  task automatic idle_inputs();
    bus.Start  = 1'b0;
    bus.Op     = 2'd0;
    bus.A      = '0;
    bus.B      = '0;
    bus.Cancel = 1'b0;
    bus.HI_WE  = 1'b0;
    bus.LO_WE  = 1'b0;
    bus.W_Data = '0;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge CLK);
    @(negedge CLK);
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (bus.Done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_result(input string nm, input logic [1:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input int lat);
    logic [63:0] e;
    e = ref_mdu(op, a, b);
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL %s latency got %0d want 33", nm, lat);
    end
    checks++;
    if ({bus.HI, bus.LO} !== e) begin
      errors++;
      $display("FAIL %s op=%0d a=%h b=%h got HI=%h LO=%h want HI=%h LO=%h",
               nm, op, a, b, bus.HI, bus.LO, e[63:32], e[31:0]);
    end
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done got %b want 0", nm, bus.Busy);
    end
`ifdef MDU_DIVZERO_FLAG_EN
    checks++;
    if (bus.DivZero !== (op[1] && b == 32'd0)) begin
      errors++;
      $display("FAIL %s divzero got %b want %b", nm, bus.DivZero,
               (op[1] && b == 32'd0));
    end
`endif
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask

  task automatic run_op(input string nm, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    int lat;
    start_op(op, a, b);
    checks++;
    if (bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_accept got %b want 1", nm, bus.Busy);
    end
    wait_done(lat);
    check_result(nm, op, a, b, lat);
  endtask

  task automatic test_reset();
    idle_inputs();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({bus.Busy, bus.Done, bus.HI, bus.LO} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b HI=%h LO=%h want all 0",
               bus.Busy, bus.Done, bus.HI, bus.LO);
    end
    RST_N = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_release got done=%b busy=%b want 0 0",
                 bus.Done, bus.Busy);
      end
    end
  endtask

  task automatic test_directed();
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_zero", 2'd3, 32'd100, 32'd0);
    run_op("div_zero", 2'd2, 32'hFFFF_FF9C, 32'd0);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mult_minmin", 2'd0, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ((i % 4) == 1) b = 32'($urandom_range(0, 15)) - 32'd8;
      if ((i % 7) == 3) b = 32'd0;
      run_op("random", op, a, b);
    end
  endtask

  task automatic test_mt();
    int lat;
    bus.HI_WE  = 1'b1;
    bus.W_Data = 32'h0000_1234;
    @(posedge CLK);
    @(negedge CLK);
    bus.HI_WE = 1'b0;
    checks++;
    if (bus.HI !== 32'h0000_1234) begin
      errors++;
      $display("FAIL mthi got %h want 00001234", bus.HI);
    end
    bus.LO_WE  = 1'b1;
    bus.W_Data = 32'h0000_5678;
    @(posedge CLK);
    @(negedge CLK);
    bus.LO_WE = 1'b0;
    checks++;
    if (bus.LO !== 32'h0000_5678) begin
      errors++;
      $display("FAIL mtlo got %h want 00005678", bus.LO);
    end
    start_op(2'd1, 32'd3, 32'd5);
    bus.LO_WE  = 1'b1;
    bus.W_Data = 32'h0000_AAAA;
    @(posedge CLK);
    @(negedge CLK);
    bus.LO_WE = 1'b0;
    checks++;
    if (bus.LO !== 32'h0000_5678) begin
      errors++;
      $display("FAIL mtlo_busy got %h want 00005678", bus.LO);
    end
    wait_done(lat);
    check_result("mt_then_op", 2'd1, 32'd3, 32'd5, lat + 1);
  endtask

  task automatic test_cancel();
    int dones;
    bus.Cancel = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.Cancel = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== exp_hi || bus.LO !== exp_lo) begin
      errors++;
      $display("FAIL cancel_idle got busy=%b HI=%h LO=%h want 0 %h %h",
               bus.Busy, bus.HI, bus.LO, exp_hi, exp_lo);
    end
    start_op(2'd3, $urandom, $urandom_range(1, 1000));
    repeat (9) @(negedge CLK);
    bus.Cancel = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.Cancel = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL cancel_busy got busy=%b done=%b want 0 0",
               bus.Busy, bus.Done);
    end
    dones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (bus.Done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || bus.HI !== exp_hi || bus.LO !== exp_lo) begin
      errors++;
      $display("FAIL cancel_hold got dones=%0d HI=%h LO=%h want 0 %h %h",
               dones, bus.HI, bus.LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_busy_start();
    logic [31:0] a, b;
    int dones, lat;
    a = $urandom;
    b = $urandom;
    start_op(2'd0, a, b);
    repeat (5) @(negedge CLK);
    start_op(2'd3, 32'd77, 32'd5);
    dones = 0;
    lat = -1;
    for (int n = 7; n <= 50; n++) begin
      @(negedge CLK);
      if (bus.Done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          lat = n;
          check_result("busy_start", 2'd0, a, b, lat);
        end
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL busy_start_dones got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    bus.HI_WE  = 1'b1;
    bus.LO_WE  = 1'b1;
    bus.W_Data = 32'hCAFE_F00D;
    start_op(2'd0, $urandom, $urandom);
    bus.HI_WE = 1'b0;
    bus.LO_WE = 1'b0;
    repeat (19) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    checks++;
    if ({bus.Busy, bus.Done, bus.HI, bus.LO} !== '0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b HI=%h LO=%h want all 0",
               bus.Busy, bus.Done, bus.HI, bus.LO);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (bus.Done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_after got dones=%0d HI=%h LO=%h want 0 0 0",
               dones, bus.HI, bus.LO);
    end
    exp_hi = '0;
    exp_lo = '0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int lat;
    run_op("b2b_first", 2'd1, $urandom, $urandom);
    a = $urandom;
    b = $urandom_range(1, 50000);
    bus.Cancel = 1'b1;
    bus.HI_WE  = 1'b1;
    bus.W_Data = 32'h0000_DEAD;
    start_op(2'd2, a, b);
    bus.Cancel = 1'b0;
    bus.HI_WE  = 1'b0;
    checks++;
    if (bus.Busy !== 1'b1 || bus.HI !== 32'h0000_DEAD) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b HI=%h want 1 0000dead",
               bus.Busy, bus.HI);
    end
    wait_done(lat);
    check_result("b2b_second", 2'd2, a, b, lat);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mt();
    test_cancel();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
